sao_offset_rdo: RTL and testbench
=================================

SAO_OFFSET_RDO -- requirements
Module: sao_offset_rdo

Interface
REQ-001 Parameter diff_clip_bit, default 4, clip width of per-pixel difference used upstream.
REQ-002 Parameter num_pix_CTU_log2, default 5, log2 of CTU edge length.
REQ-003 Parameter num_accu_len, default num_pix_CTU_log2*2-1, accumulator width exponent shared with the statistics stage.
REQ-004 Parameter n_category, default 4, number of EO categories.
REQ-005 Parameter lambda_bit, default 8, width of the rate multiplier.
REQ-006 Parameter cost_bit, default 20, signed per-category cost width.
REQ-007 clk  input  1  single clock for all state.
REQ-008 arst_n  input  1  asynchronous active-low reset.
REQ-009 start_i  input  1  one-cycle pulse; sum_i, num_i and lambda_i are valid.
REQ-010 sum_i[0:n_category-1]  input  signed num_accu_len+diff_clip_bit+1  per-category sum of (org-rec).
REQ-011 num_i[0:n_category-1]  input  num_accu_len+1  per-category pixel count.
REQ-012 lambda_i  input  lambda_bit  rate weight.
REQ-013 busy_o  output  1  evaluation in progress.
REQ-014 done_o  output  1  one-cycle pulse; results valid.
REQ-015 offset_o[0:n_category-1]  output  signed 4  chosen offset, range -7..+7.
REQ-016 cost_o  output  signed cost_bit+2  sum of the chosen per-category costs.

Function
REQ-017 FSM states are IDLE, EVAL and DONE; IDLE->EVAL on start_i, EVAL->DONE after the final candidate, DONE->IDLE unconditionally.
REQ-018 Inputs are registered on the start_i edge in IDLE; start_i in EVAL or DONE is ignored, and the latched values are unaffected by later input changes.
REQ-019 EVAL visits categories 0..3 in order, evaluating magnitudes m=7 down to 0, one candidate per cycle, for exactly 32 EVAL cycles.
REQ-020 Sign rule: categories 0,1 use s=+1; categories 2,3 use s=-1; the offset equals s*m.
REQ-021 Candidate cost = num*m*m - 2*s*sum*m + lambda*rate(m), with rate(m)=m+1 for m<7 and rate(7)=7; computation is exact in cost_bit signed with no overflow at maximum input values.
REQ-022 A candidate replaces the current best when its cost <= best cost; as m descends, ties resolve to the smaller magnitude.
REQ-023 num==0 for a category forces offset 0 and a cost contribution of 0, regardless of sum and lambda.
REQ-024 Latency: start_i sampled at edge 0; EVAL occupies cycles 1..32; done_o is high in cycle 33 only.
REQ-025 busy_o is high in cycles 1..33 and low otherwise.
REQ-026 offset_o and cost_o update only in the done_o cycle and hold until the next done_o.
REQ-027 start_i in the same cycle that DONE returns to IDLE is ignored; a new start is accepted from cycle 34.

Reset
REQ-028 arst_n low asynchronously forces IDLE, busy_o=0, done_o=0, all offset_o=0 and cost_o=0, and clears all latched inputs and counters.
REQ-029 Reset asserted mid-EVAL abandons the run, and no done_o is produced for it.
REQ-030 After reset release, the first start_i is accepted on the first clk edge.

Structure
REQ-031 The shared package sao_pkg holds n_category, SAO_MAX_OFFSET=7, the cost width, and the FSM state enum.
REQ-032 One combinational sub-module, sao_cost_calc, maps (num, sum, m, s, lambda) to a candidate cost; the wrapper holds the FSM, the counters and the best-cost registers.

Verification
REQ-033 Cat0 sum=+40 num=10, lambda=0, other nums 0 -> offset_o[0]=+4, cost_o=-160, done_o at cycle 33.
REQ-034 Same input with lambda=10 -> tie between m=3 and m=4 at -110 resolves to offset_o[0]=+3, cost_o=-110.
REQ-035 Cat0 sum=-40 num=10, lambda=0 -> sign violation gives offset_o[0]=0, cost_o=0; cat2 sum=-30 num=10 -> offset_o[2]=-3, cost -90.
REQ-036 Cat1 sum=500 num=10, lambda=0 -> clipped to offset_o[1]=+7, cost_o=-6510.
REQ-037 All num=0, lambda=255 -> all offsets 0, cost_o=0; start_i repulsed at cycle 5 is ignored, giving exactly one done_o.
REQ-038 arst_n pulsed at cycle 15 of a run -> outputs 0, no done_o; the next start completes normally in 33 cycles.

Source files
------------

// File: rtl/sao_pkg.sv
// Shared constants, FSM state type and rate helper for the SAO offset
// rate-distortion search.
package sao_pkg;

    localparam int N_CATEGORY     = 4;
    localparam int SAO_MAX_OFFSET = 7;
    localparam int COST_W         = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } sao_state_e;

    // Offset rate: magnitude plus one, except the top magnitude which needs no terminator.
    function automatic logic [3:0] sao_rate(input logic [2:0] mag);
        logic [3:0] rate;
        if (mag == 3'(SAO_MAX_OFFSET)) begin
            rate = 4'(SAO_MAX_OFFSET);
        end else begin
            rate = {1'b0, mag} + 4'd1;
        end
        return rate;
    endfunction

endpackage

// File: rtl/sao_cost_calc.sv
// Combinational cost of one offset candidate:
// num*m*m - 2*s*sum*m + lambda*rate(m), evaluated exactly in cost_bit signed.
module sao_cost_calc
    import sao_pkg::*;
#(
    parameter int num_w      = 10,
    parameter int sum_w      = 14,
    parameter int lambda_bit = 8,
    parameter int cost_bit   = COST_W
) (
    input  logic [num_w-1:0]           num,
    input  logic signed [sum_w-1:0]    sum,
    input  logic [2:0]                 mag,
    input  logic                       neg,
    input  logic [lambda_bit-1:0]      lambda,
    output logic signed [cost_bit-1:0] cost
);

    logic signed [cost_bit-1:0] num_s;
    logic signed [cost_bit-1:0] sum_s;
    logic signed [cost_bit-1:0] mag_s;
    logic signed [cost_bit-1:0] lam_s;
    logic signed [cost_bit-1:0] rate_s;
    logic signed [cost_bit-1:0] dist_s;
    logic signed [cost_bit-1:0] cross_s;

    // Widen every operand first so all products are formed at full cost width.
    always_comb begin
        num_s   = cost_bit'(num);
        sum_s   = cost_bit'(sum);
        mag_s   = cost_bit'(mag);
        lam_s   = cost_bit'(lambda);
        rate_s  = cost_bit'(sao_rate(mag));
        dist_s  = num_s * mag_s * mag_s;
        cross_s = (sum_s * mag_s) <<< 1;
        if (neg) begin
            cost = dist_s + cross_s + lam_s * rate_s;
        end else begin
            cost = dist_s - cross_s + lam_s * rate_s;
        end
    end

endmodule

// File: rtl/sao_offset_rdo.sv
// SAO edge-offset RDO: sweeps magnitudes 7..0 for each category, one
// candidate per cycle, and reports the cheapest signed offset per category.
module sao_offset_rdo
    import sao_pkg::*;
#(
    parameter int diff_clip_bit    = 4,
    parameter int num_pix_CTU_log2 = 5,
    parameter int num_accu_len     = num_pix_CTU_log2 * 2 - 1,
    parameter int n_category       = N_CATEGORY,
    parameter int lambda_bit       = 8,
    parameter int cost_bit         = COST_W
) (
    input  logic                                         clk,
    input  logic                                         arst_n,
    input  logic                                         start_i,
    input  logic signed [num_accu_len+diff_clip_bit:0]   sum_i [0:n_category-1],
    input  logic [num_accu_len:0]                        num_i [0:n_category-1],
    input  logic [lambda_bit-1:0]                        lambda_i,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic signed [3:0]                            offset_o [0:n_category-1],
    output logic signed [cost_bit+1:0]                   cost_o
);

    localparam int SUM_W = num_accu_len + diff_clip_bit + 1;
    localparam int NUM_W = num_accu_len + 1;
    localparam int CAT_W = $clog2(n_category);
    localparam int CNT_W = CAT_W + 3;
    localparam int TOT_W = cost_bit + 2;

    sao_state_e                 state_r;
    sao_state_e                 state_nxt_s;
    logic [CNT_W-1:0]           cnt_r;
    logic signed [SUM_W-1:0]    sum_r [0:n_category-1];
    logic [NUM_W-1:0]           num_r [0:n_category-1];
    logic [lambda_bit-1:0]      lambda_r;
    logic signed [cost_bit-1:0] best_cost_r;
    logic [2:0]                 best_mag_r;
    logic signed [3:0]          off_acc_r [0:n_category-1];
    logic signed [TOT_W-1:0]    total_r;

    logic [CAT_W-1:0]           cat_s;
    logic [2:0]                 mag_s;
    logic                       neg_s;
    logic                       cat_end_s;
    logic                       last_s;
    logic signed [cost_bit-1:0] cost_s;
    logic                       take_s;
    logic signed [cost_bit-1:0] chosen_cost_s;
    logic [2:0]                 chosen_mag_s;
    logic signed [3:0]          off_s;
    logic signed [TOT_W-1:0]    contrib_s;
    logic                       load_s;
    logic                       eval_s;
    logic                       busy_nxt_s;
    logic                       done_nxt_s;

    // Counter decode: upper bits pick the category, low three bits walk magnitude downward.
    always_comb begin
        cat_s     = cnt_r[CNT_W-1:3];
        mag_s     = 3'(SAO_MAX_OFFSET) - cnt_r[2:0];
        neg_s     = (cat_s >= CAT_W'(n_category / 2));
        cat_end_s = (cnt_r[2:0] == 3'd7);
        last_s    = (cnt_r == {CNT_W{1'b1}});
    end

    sao_cost_calc #(
        .num_w      (NUM_W),
        .sum_w      (SUM_W),
        .lambda_bit (lambda_bit),
        .cost_bit   (cost_bit)
    ) u_cost (
        .num    (num_r[cat_s]),
        .sum    (sum_r[cat_s]),
        .mag    (mag_s),
        .neg    (neg_s),
        .lambda (lambda_r),
        .cost   (cost_s)
    );

    // Running minimum; "<=" lets a later (smaller) magnitude win ties.
    always_comb begin
        take_s = (mag_s == 3'(SAO_MAX_OFFSET)) || (cost_s <= best_cost_r);
        if (take_s) begin
            chosen_cost_s = cost_s;
            chosen_mag_s  = mag_s;
        end else begin
            chosen_cost_s = best_cost_r;
            chosen_mag_s  = best_mag_r;
        end
        if (num_r[cat_s] == {NUM_W{1'b0}}) begin
            off_s     = 4'sd0;
            contrib_s = {TOT_W{1'b0}};
        end else if (neg_s) begin
            off_s     = 4'sd0 - $signed({1'b0, chosen_mag_s});
            contrib_s = TOT_W'(chosen_cost_s);
        end else begin
            off_s     = $signed({1'b0, chosen_mag_s});
            contrib_s = TOT_W'(chosen_cost_s);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_EVAL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EVAL;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode; busy/done are registered from the next state.
    always_comb begin
        load_s     = 1'b0;
        eval_s     = 1'b0;
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
        case (state_r)
            ST_IDLE: load_s = start_i;
            ST_EVAL: eval_s = 1'b1;
            ST_DONE: load_s = 1'b0;
            default: load_s = 1'b0;
        endcase
    end

    // Input latch, candidate counter and per-category accumulation.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            lambda_r    <= {lambda_bit{1'b0}};
            best_cost_r <= {cost_bit{1'b0}};
            best_mag_r  <= 3'd0;
            total_r     <= {TOT_W{1'b0}};
            for (int i = 0; i < n_category; i++) begin
                sum_r[i]     <= {SUM_W{1'b0}};
                num_r[i]     <= {NUM_W{1'b0}};
                off_acc_r[i] <= 4'sd0;
            end
        end else if (load_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            lambda_r <= lambda_i;
            total_r  <= {TOT_W{1'b0}};
            for (int i = 0; i < n_category; i++) begin
                sum_r[i]     <= sum_i[i];
                num_r[i]     <= num_i[i];
                off_acc_r[i] <= 4'sd0;
            end
        end else if (eval_s) begin
            cnt_r       <= cnt_r + CNT_W'(1);
            best_cost_r <= chosen_cost_s;
            best_mag_r  <= chosen_mag_s;
            if (cat_end_s) begin
                off_acc_r[cat_s] <= off_s;
                total_r          <= total_r + contrib_s;
            end
        end
    end

    // Registered outputs; results are published together with done_o.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_o <= 1'b0;
            done_o <= 1'b0;
            cost_o <= {TOT_W{1'b0}};
            for (int i = 0; i < n_category; i++) begin
                offset_o[i] <= 4'sd0;
            end
        end else begin
            busy_o <= busy_nxt_s;
            done_o <= done_nxt_s;
            if (eval_s && last_s) begin
                cost_o <= total_r + contrib_s;
                for (int i = 0; i < n_category; i++) begin
                    if (CAT_W'(i) == cat_s) begin
                        offset_o[i] <= off_s;
                    end else begin
                        offset_o[i] <= off_acc_r[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sao_offset_rdo.sv
// Directed bench for sao_offset_rdo with hand-computed offsets and costs.
module tb_sao_offset_rdo;

    localparam int SW = 14;
    localparam int NW = 10;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 start_i;
    logic signed [SW-1:0] sum_i [0:3];
    logic [NW-1:0]        num_i [0:3];
    logic [7:0]           lambda_i;
    logic                 busy_o;
    logic                 done_o;
    logic signed [3:0]    offset_o [0:3];
    logic signed [21:0]   cost_o;

    int checks = 0;
    int errs   = 0;

    sao_offset_rdo dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .start_i  (start_i),
        .sum_i    (sum_i),
        .num_i    (num_i),
        .lambda_i (lambda_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .offset_o (offset_o),
        .cost_o   (cost_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cat(input int i, input int s, input int n);
        sum_i[i] = SW'(s);
        num_i[i] = NW'(n);
    endtask

    task automatic clear_in();
        for (int i = 0; i < 4; i++) begin
            set_cat(i, 0, 0);
        end
        lambda_i = 8'd0;
    endtask

    task automatic scramble();
        for (int i = 0; i < 4; i++) begin
            sum_i[i] = SW'($urandom());
            num_i[i] = NW'($urandom());
        end
        lambda_i = 8'($urandom());
    endtask

    // Pulse start for the edge that begins cycle 1, then disturb the inputs.
    task automatic issue_start();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        scramble();
    endtask

    // Called just after the start edge; returns the cycle in which done_o appears.
    task automatic wait_done(input int rep_cyc, output int done_cyc, output bit busy_ok);
        int cyc;
        cyc      = 1;
        done_cyc = 0;
        busy_ok  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (done_o === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            start_i = (cyc == rep_cyc);
            @(posedge clk);
            #1;
            start_i = 1'b0;
            cyc++;
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) cnt++;
        end
    endtask

    task automatic check_out(input string tag, input int o0, input int o1, input int o2, input int o3, input int c);
        chk({tag, ".off0"}, offset_o[0], o0);
        chk({tag, ".off1"}, offset_o[1], o1);
        chk({tag, ".off2"}, offset_o[2], o2);
        chk({tag, ".off3"}, offset_o[3], o3);
        chk({tag, ".cost"}, cost_o, c);
    endtask

    task automatic finish_run(input string tag, input int rep_cyc, input int o0, input int o1, input int o2, input int o3, input int c);
        int  dc;
        bit  bok;
        wait_done(rep_cyc, dc, bok);
        chk({tag, ".done_cycle"}, dc, 33);
        chk({tag, ".busy"}, bok, 1);
        check_out(tag, o0, o1, o2, o3, c);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done_o, 0);
        chk({tag, ".busy_end"}, busy_o, 0);
    endtask

    initial begin
        int n;
        int dc;
        bit bok;

        arst_n  = 1'b0;
        start_i = 1'b0;
        clear_in();
        #12;
        chk("reset.busy", busy_o, 0);
        chk("reset.done", done_o, 0);
        check_out("reset", 0, 0, 0, 0, 0);

        // Cat0 sum=40 num=10; other categories carry sums but zero counts.
        set_cat(0, 40, 10);
        set_cat(1, -500, 0);
        set_cat(3, 300, 0);
        @(negedge clk);
        arst_n  = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        scramble();
        finish_run("basic", 0, 4, 0, 0, 0, -160);

        clear_in();
        set_cat(0, 40, 10);
        set_cat(2, 900, 0);
        lambda_i = 8'd10;
        issue_start();
        finish_run("tie", 0, 3, 0, 0, 0, -110);

        clear_in();
        set_cat(0, -40, 10);
        set_cat(2, -30, 10);
        issue_start();
        finish_run("sign", 0, 0, 0, -3, 0, -90);

        clear_in();
        set_cat(1, 500, 10);
        issue_start();
        finish_run("clip", 0, 0, 7, 0, 0, -6510);

        // Mixed: cat1 settles at m=0 whose cost is lambda, not zero.
        clear_in();
        set_cat(0, 12, 3);
        set_cat(1, 0, 2);
        set_cat(3, -25, 5);
        lambda_i = 8'd4;
        issue_start();
        finish_run("mixed", 0, 3, 0, 0, -5, -126);

        clear_in();
        set_cat(0, 1000, 0);
        set_cat(1, -1000, 0);
        set_cat(2, -777, 0);
        set_cat(3, 555, 0);
        lambda_i = 8'd255;
        issue_start();
        finish_run("zero_num", 5, 0, 0, 0, 0, 0);
        count_done(40, n);
        chk("zero_num.extra_done", n, 0);
        check_out("hold", 0, 0, 0, 0, 0);

        // Start held through the DONE->IDLE edge is ignored, then taken in cycle 34.
        clear_in();
        set_cat(0, 40, 10);
        issue_start();
        wait_done(0, dc, bok);
        chk("restart.first_done", dc, 33);
        clear_in();
        set_cat(0, 40, 10);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart.ignored", busy_o, 0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        scramble();
        finish_run("restart", 0, 4, 0, 0, 0, -160);

        // Reset in cycle 15 abandons the run.
        clear_in();
        set_cat(1, 500, 10);
        issue_start();
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
        end
        arst_n = 1'b0;
        #1;
        chk("midrst.busy", busy_o, 0);
        chk("midrst.done", done_o, 0);
        check_out("midrst", 0, 0, 0, 0, 0);
        #2;
        arst_n = 1'b1;
        count_done(40, n);
        chk("midrst.no_done", n, 0);

        clear_in();
        set_cat(1, 500, 10);
        issue_start();
        finish_run("after_rst", 0, 0, 7, 0, 0, -6510);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
